// File: rtl/multi_cnt.sv
`timescale 1ns/1ps
// multi_cnt: OBI-attached bank of NumCh prescaled up-counters with threshold
// match, auto-reload or one-shot mode, W1C terminal-count flags and interrupts.
module multi_cnt #(
    parameter int unsigned NumCh    = 4,
    parameter int unsigned CntWidth = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic [NumCh-1:0] intr_vec_o,
    output logic             intr_o
);

    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegThresh = 2'd1,
        RegValue  = 2'd2,
        RegStatus = 2'd3
    } reg_e;

    reg_e                           reg_sel;
    logic [NumCh-1:0]               ch_sel;
    logic [NumCh-1:0]               wr_sel;
    logic [NumCh-1:0]               tick;
    logic [NumCh-1:0]               clr;
    logic [NumCh-1:0]               val_wr;
    logic [NumCh-1:0]               w1c;
    logic [NumCh-1:0]               tc_set;

    logic [NumCh-1:0]               en_q, en_d;
    logic [NumCh-1:0]               mode_q, mode_d;
    logic [NumCh-1:0]               ie_q, ie_d;
    logic [NumCh-1:0]               tc_q, tc_d;
    logic [NumCh-1:0][7:0]          presc_q, presc_d;
    logic [NumCh-1:0][7:0]          pcnt_q, pcnt_d;
    logic [NumCh-1:0][CntWidth-1:0] thresh_q, thresh_d;
    logic [NumCh-1:0][CntWidth-1:0] value_q, value_d;

    logic                           rvalid_q;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           unused_bits;

    assign gnt_o       = req_i;
    assign reg_sel     = reg_e'(addr_i[3:2]);
    assign unused_bits = ^{be_i, addr_i[31:8], addr_i[1:0], wdata_i[31:16], wdata_i[7:4]};

    // A channel is hit only in the lower half of the window; channels at or
    // beyond NumCh never match, which makes them unmapped.
    always_comb begin
        ch_sel = '0;
        for (int unsigned c = 0; c < NumCh; c++) begin
            ch_sel[c] = !addr_i[7] && (addr_i[6:4] == 3'(c));
        end
    end

    always_comb begin
        wr_sel = '0;
        tick   = '0;
        clr    = '0;
        val_wr = '0;
        w1c    = '0;
        for (int unsigned c = 0; c < NumCh; c++) begin
            wr_sel[c] = req_i && we_i && ch_sel[c];
            tick[c]   = en_q[c] && (pcnt_q[c] == presc_q[c]);
            clr[c]    = wr_sel[c] && (reg_sel == RegCtrl) && wdata_i[2];
            val_wr[c] = wr_sel[c] && (reg_sel == RegValue);
            w1c[c]    = wr_sel[c] && (reg_sel == RegStatus) && wdata_i[0];
        end
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        ie_d     = ie_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        thresh_d = thresh_q;
        value_d  = value_q;
        tc_set   = '0;
        for (int unsigned c = 0; c < NumCh; c++) begin
            if (en_q[c]) begin
                pcnt_d[c] = tick[c] ? 8'd0 : pcnt_q[c] + 8'd1;
            end

            // A VALUE write or CLR consumes the tick entirely.
            if (tick[c] && !clr[c] && !val_wr[c]) begin
                if (value_q[c] == thresh_q[c]) begin
                    tc_set[c] = 1'b1;
                    if (mode_q[c]) begin
                        en_d[c] = 1'b0;
                    end else begin
                        value_d[c] = '0;
                    end
                end else begin
                    value_d[c] = value_q[c] + CntWidth'(1);
                end
            end

            if (wr_sel[c] && (reg_sel == RegCtrl)) begin
                en_d[c]    = wdata_i[0];
                mode_d[c]  = wdata_i[1];
                ie_d[c]    = wdata_i[3];
                presc_d[c] = wdata_i[15:8];
                if (wdata_i[2]) begin
                    value_d[c] = '0;
                    pcnt_d[c]  = 8'd0;
                end
            end

            if (wr_sel[c] && (reg_sel == RegThresh)) begin
                thresh_d[c] = wdata_i[CntWidth-1:0];
            end

            if (val_wr[c]) begin
                value_d[c] = wdata_i[CntWidth-1:0];
            end
        end
        tc_d = (tc_q & ~w1c) | tc_set;
    end

    always_comb begin
        rdata_d = '0;
        if (req_i && !we_i) begin
            for (int unsigned c = 0; c < NumCh; c++) begin
                if (ch_sel[c]) begin
                    unique case (reg_sel)
                        RegCtrl:   rdata_d = {16'h0, presc_q[c], 4'h0, ie_q[c], 1'b0,
                                              mode_q[c], en_q[c]};
                        RegThresh: rdata_d[CntWidth-1:0] = thresh_q[c];
                        RegValue:  rdata_d[CntWidth-1:0] = value_q[c];
                        RegStatus: rdata_d[0] = tc_q[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= '0;
            mode_q   <= '0;
            ie_q     <= '0;
            tc_q     <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            thresh_q <= '0;
            value_q  <= '0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            ie_q     <= ie_d;
            tc_q     <= tc_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            thresh_q <= thresh_d;
            value_q  <= value_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign intr_vec_o = tc_q & ie_q;
    assign intr_o     = |intr_vec_o;

endmodule

// File: doc/multi_cnt.md
MULTI_CNT -- requirements
Module: multi_cnt

Interface
REQ-001 Parameters SHALL be:
- NumCh, default 4, number of counter channels, legal range 1..8.
- CntWidth, default 32, counter width in bits, legal range 8..32.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address; only bits [7:0] decoded.
- we_i  in  1  write enable.
- be_i  in  4  byte enables; ignored, all writes are full-word.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- intr_vec_o  out  NumCh  per-channel interrupt.
- intr_o  out  1  OR of intr_vec_o.

Function
REQ-003 Bus protocol:
- gnt_o SHALL equal req_i combinationally; every request is accepted in its request cycle.
- rvalid_o SHALL assert exactly one cycle after each accepted request, reads and writes alike.
- rdata_o SHALL be registered and valid while rvalid_o=1; it SHALL be 0 when rvalid_o=0 and for write responses.
REQ-004 Decode:
- Channel c = addr_i[6:4]; register = addr_i[3:2].
- Register map: 0=CTRL, 1=THRESH, 2=VALUE, 3=STATUS.
- Addresses with addr_i[7]=1 or c>=NumCh are unmapped: writes have no effect, reads return 0.
REQ-005 CTRL fields:
- [0] EN, read/write.
- [1] MODE, read/write; 0 = auto-reload, 1 = one-shot.
- [2] CLR, write-only; reads 0.
- [3] IE, read/write.
- [15:8] PRESC, read/write.
- All other bits read 0.
REQ-006 THRESH and VALUE SHALL be CntWidth bits wide; bits above CntWidth SHALL be ignored on write and read as 0.
REQ-007 STATUS[0] SHALL be TC (terminal count), cleared by writing 1 (W1C); all other bits read 0.
REQ-008 Prescaler: each channel SHALL have an 8-bit prescaler counter. While EN=1 it advances each cycle, and a tick occurs when it equals PRESC, at which point it returns to 0. A tick therefore occurs every PRESC+1 cycles.
REQ-009 On a tick with VALUE==THRESH:
- TC SHALL be set.
- Auto-reload: VALUE SHALL load 0 and counting SHALL continue.
- One-shot: VALUE SHALL hold and EN SHALL clear in the same cycle.
REQ-010 On a tick with VALUE!=THRESH, VALUE SHALL increment modulo 2^CntWidth. If software has set VALUE>THRESH, the count wraps through 0 before matching.
REQ-011 THRESH=0 in auto-reload SHALL produce TC on every tick with VALUE staying 0.
REQ-012 A CTRL write with CLR=1 SHALL zero VALUE and the prescaler counter in the next cycle; the other CTRL fields SHALL take the written values in the same write.
REQ-013 Precedence on simultaneous events:
- A bus write to VALUE SHALL take priority over a tick in the same cycle.
- CLR SHALL take priority over a tick.
- A TC set SHALL take priority over a W1C clear in the same cycle.
REQ-014 While EN=0, VALUE and the prescaler counter SHALL hold.
REQ-015 intr_vec_o[c] SHALL equal TC[c] & IE[c], registered-state derived, with no combinational path from bus inputs.

Reset
REQ-016 On rst_ni=0, asynchronously:
- All CTRL fields, THRESH, VALUE, TC and prescaler counters SHALL reset to 0.
- rvalid_o, rdata_o, intr_vec_o and intr_o SHALL reset to 0.
REQ-017 Reset asserted mid-transaction SHALL drop any pending response; no rvalid_o SHALL follow the release of reset.

Verification
REQ-018 Reset then read of every mapped register -> all read 0; each read produces rvalid_o exactly 1 cycle after its request.
REQ-019 Ch0 auto-reload: THRESH=3, PRESC=0, EN=1, IE=1 -> VALUE sequence 0,1,2,3,0; TC and intr_o=1 after the 4th tick; a W1C to STATUS drops intr_o the next cycle.
REQ-020 Ch1 one-shot: THRESH=2, PRESC=1 -> a tick every 2 cycles; VALUE holds 2 with EN=0 after 6 cycles; TC=1.
REQ-021 Collision cases:
- W1C in the same cycle as a TC-setting tick -> TC stays 1.
- VALUE write of 0x10 coinciding with a tick -> VALUE reads 0x10.
REQ-022 Boundary cases with CntWidth=8:
- VALUE=0xFE, THRESH=0x01 -> sequence 0xFE, 0xFF, 0x00, 0x01, then TC.
- Read at addr 0x80 or at channel NumCh -> rdata 0.
REQ-023 Reset asserted with ch0 at VALUE=5 and a read pending -> all outputs 0 immediately; no rvalid_o after release.
